// File: rtl/vend_pkg.sv
// Shared encodings for the parametrised vending controller: one-hot states and coin unit values.
package vend_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    ACCUM  = 4'b0010,
    VEND   = 4'b0100,
    REFUND = 4'b1000
  } vend_state_t;

  localparam int COIN_HALF = 1;
  localparam int COIN_ONE  = 2;

endpackage

// File: rtl/vend_fsm_param_if.sv
// Coin/button front-end and actuator signals of the vending controller, grouped as one bundle.
interface vend_fsm_param_if #(
  parameter int CREDIT_W = 4,
  parameter int STOCK_W  = 8
);

  logic                pi_money_half;
  logic                pi_money_one;
  logic                pi_cancel;
  logic                pi_refill;
  logic [STOCK_W-1:0]  pi_refill_cnt;
  logic                po_cola;
  logic                po_change_vld;
  logic [CREDIT_W-1:0] po_change;
  logic                po_coin_rej;
  logic [CREDIT_W-1:0] po_credit;
  logic                po_sold_out;

  // master is the front-end side, slave is the controller
  modport master (
    output pi_money_half, pi_money_one, pi_cancel, pi_refill, pi_refill_cnt,
    input  po_cola, po_change_vld, po_change, po_coin_rej, po_credit, po_sold_out
  );

  modport slave (
    input  pi_money_half, pi_money_one, pi_cancel, pi_refill, pi_refill_cnt,
    output po_cola, po_change_vld, po_change, po_coin_rej, po_credit, po_sold_out
  );

endinterface

// File: rtl/vend_stock_cnt.sv
// Stock counter: refill load (wins over decrement), non-wrapping decrement, registered sold-out flag.
module vend_stock_cnt #(
  parameter int STOCK_W    = 8,
  parameter int STOCK_INIT = 10
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               load,
  input  logic [STOCK_W-1:0] load_val,
  input  logic               dec,
  output logic [STOCK_W-1:0] stock,
  output logic               sold_out
);

  if (STOCK_INIT < 0 || STOCK_INIT >= (2**STOCK_W)) begin : g_bad_init
    $error("vend_stock_cnt: STOCK_INIT does not fit in STOCK_W bits");
  end

  // sold_out lags the counter by one cycle
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stock    <= STOCK_W'(STOCK_INIT);
      sold_out <= (STOCK_INIT == 0);
    end else begin
      if (load)
        stock <= load_val;
      else if (dec && stock != '0)
        stock <= stock - 1'b1;
      sold_out <= (stock == '0);
    end
  end

endmodule

// File: rtl/vend_fsm_param.sv
// Parametrised vending controller: half/one coin credit accumulation, vend with change, cancel refund.
module vend_fsm_param
  import vend_pkg::*;
#(
  parameter int PRICE      = 5,
  parameter int CREDIT_W   = 4,
  parameter int STOCK_W    = 8,
  parameter int STOCK_INIT = 10
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  vend_fsm_param_if.slave  bus
);

  if (PRICE < 2 || PRICE > (2**CREDIT_W) - 2) begin : g_bad_price
    $error("vend_fsm_param: PRICE must be in 2..2**CREDIT_W-2 so PRICE+1 fits CREDIT_W");
  end

  localparam logic [CREDIT_W-1:0] PRICE_U = CREDIT_W'(PRICE);

  vend_state_t         state;
  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] credit_sum;
  logic [CREDIT_W-1:0] change_q;
  logic                cola_q;
  logic                change_vld_q;
  logic                coin_rej_q;
  logic                coin_any;
  logic                coin_both;
  logic                sold_lock;
  logic                sold_out;
  logic                stock_dec;
  logic [STOCK_W-1:0]  stock;

  assign coin_any   = bus.pi_money_half | bus.pi_money_one;
  assign coin_both  = bus.pi_money_half & bus.pi_money_one;
  assign coin_val   = bus.pi_money_one ? CREDIT_W'(COIN_ONE) : CREDIT_W'(COIN_HALF);
  assign credit_sum = credit + coin_val;
  // Raw stock==0 also locks, closing the one-cycle window before sold_out catches up.
  assign sold_lock  = sold_out | (stock == '0);
  assign stock_dec  = (state == VEND);

  vend_stock_cnt #(
    .STOCK_W    (STOCK_W),
    .STOCK_INIT (STOCK_INIT)
  ) u_stock (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .load     (bus.pi_refill),
    .load_val (bus.pi_refill_cnt),
    .dec      (stock_dec),
    .stock    (stock),
    .sold_out (sold_out)
  );

  // Pulses are registered on the edge that enters VEND/REFUND so they coincide with that state.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= IDLE;
      credit       <= '0;
      cola_q       <= 1'b0;
      change_vld_q <= 1'b0;
      change_q     <= '0;
      coin_rej_q   <= 1'b0;
    end else begin
      cola_q       <= 1'b0;
      change_vld_q <= 1'b0;
      change_q     <= '0;
      coin_rej_q   <= 1'b0;
      case (state)
        IDLE, ACCUM: begin
          if (bus.pi_cancel && credit != '0) begin
            state        <= REFUND;
            change_vld_q <= 1'b1;
            change_q     <= credit;
            coin_rej_q   <= coin_any;
          end else if (coin_any) begin
            if (coin_both || sold_lock) begin
              coin_rej_q <= 1'b1;
            end else if (credit_sum >= PRICE_U) begin
              state  <= VEND;
              credit <= credit_sum;
              cola_q <= 1'b1;
              if (credit_sum > PRICE_U) begin
                change_vld_q <= 1'b1;
                change_q     <= credit_sum - PRICE_U;
              end
            end else begin
              state  <= ACCUM;
              credit <= credit_sum;
            end
          end
        end
        VEND, REFUND: begin
          state      <= IDLE;
          credit     <= '0;
          coin_rej_q <= coin_any;
        end
        default: begin
          state  <= IDLE;
          credit <= '0;
        end
      endcase
    end
  end

  assign bus.po_cola       = cola_q;
  assign bus.po_change_vld = change_vld_q;
  assign bus.po_change     = change_q;
  assign bus.po_coin_rej   = coin_rej_q;
  assign bus.po_credit     = credit;
  assign bus.po_sold_out   = sold_out;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Scoreboard bench for vend_fsm_param: stimulus queues expected pulse events, a monitor pops and compares.
module tb_vend_fsm_param;

  logic sys_clk;
  logic sys_rst;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic       cola;
    logic       vld;
    logic [3:0] chg;
    logic       rej;
    logic [3:0] credit;
  } exp_t;

  exp_t expQ[$];

  vend_fsm_param_if #(.CREDIT_W(4), .STOCK_W(8)) vif ();

  vend_fsm_param #(
    .PRICE      (5),
    .CREDIT_W   (4),
    .STOCK_W    (8),
    .STOCK_INIT (10)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (vif)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushExp(input logic cola, input logic vld, input logic [3:0] chg,
                         input logic rej, input logic [3:0] credit);
    exp_t e;
    e.cola = cola; e.vld = vld; e.chg = chg; e.rej = rej; e.credit = credit;
    expQ.push_back(e);
  endtask

  // drive one cycle of inputs, then release them 1 time unit after the sampling edge
  task automatic applyStimulus(input logic half, input logic one, input logic cancel,
                               input logic refill, input logic [7:0] cnt);
    vif.pi_money_half = half;
    vif.pi_money_one  = one;
    vif.pi_cancel     = cancel;
    vif.pi_refill     = refill;
    vif.pi_refill_cnt = cnt;
    @(posedge sys_clk);
    #1;
    vif.pi_money_half = 1'b0;
    vif.pi_money_one  = 1'b0;
    vif.pi_cancel     = 1'b0;
    vif.pi_refill     = 1'b0;
    vif.pi_refill_cnt = '0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  // monitor: every pulse event must match the next queued expectation
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (vif.po_cola || vif.po_change_vld || vif.po_coin_rej) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_event: cola=%0b vld=%0b chg=%0d rej=%0b, required no event at %0t",
                   vif.po_cola, vif.po_change_vld, vif.po_change, vif.po_coin_rej, $time);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("ev_cola",   int'(vif.po_cola),       int'(e.cola));
          checkOutput("ev_vld",    int'(vif.po_change_vld), int'(e.vld));
          checkOutput("ev_change", int'(vif.po_change),     int'(e.chg));
          checkOutput("ev_rej",    int'(vif.po_coin_rej),   int'(e.rej));
          checkOutput("ev_credit", int'(vif.po_credit),     int'(e.credit));
        end
      end else begin
        checkOutput("change_idle_zero", int'(vif.po_change), 0);
      end
    end
  end

  initial begin
    vif.pi_money_half = 1'b0;
    vif.pi_money_one  = 1'b0;
    vif.pi_cancel     = 1'b0;
    vif.pi_refill     = 1'b0;
    vif.pi_refill_cnt = '0;
    sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    checkOutput("rst_credit",   int'(vif.po_credit),     0);
    checkOutput("rst_sold_out", int'(vif.po_sold_out),   0);
    checkOutput("rst_cola",     int'(vif.po_cola),       0);
    checkOutput("rst_vld",      int'(vif.po_change_vld), 0);
    checkOutput("rst_rej",      int'(vif.po_coin_rej),   0);
    checkOutput("rst_stock",    int'(dut.u_stock.stock), 10);
    checkOutput("rst_state",    int'(dut.state),         1);
    sys_rst = 1'b0;

    $display("[TB] one, one, half -> exact price");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    checkOutput("t1_credit2", int'(vif.po_credit), 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    checkOutput("t1_credit4", int'(vif.po_credit), 4);
    pushExp(1'b1, 1'b0, 4'd0, 1'b0, 4'd5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    idle();
    checkOutput("t1_credit0", int'(vif.po_credit), 0);
    checkOutput("t1_stock9",  int'(dut.u_stock.stock), 9);

    $display("[TB] one x3 -> vend with change");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    pushExp(1'b1, 1'b1, 4'd1, 1'b0, 4'd6);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    idle();
    checkOutput("t2_credit0", int'(vif.po_credit), 0);
    checkOutput("t2_stock8",  int'(dut.u_stock.stock), 8);

    $display("[TB] cancel with zero credit is ignored");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    checkOutput("t3_idle_state", int'(dut.state), 1);

    $display("[TB] half then cancel+one -> refund and reject");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    checkOutput("t3_credit1", int'(vif.po_credit), 1);
    pushExp(1'b0, 1'b1, 4'd1, 1'b1, 4'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    idle();
    checkOutput("t3_credit0", int'(vif.po_credit), 0);

    $display("[TB] both coins together, coin during VEND");
    pushExp(1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    pushExp(1'b0, 1'b0, 4'd0, 1'b1, 4'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    checkOutput("t5_credit_kept", int'(vif.po_credit), 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    pushExp(1'b1, 1'b0, 4'd0, 1'b0, 4'd5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    pushExp(1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    checkOutput("t5_credit0", int'(vif.po_credit), 0);
    checkOutput("t5_stock7",  int'(dut.u_stock.stock), 7);
    idle();

    $display("[TB] sold-out lockout and refill");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
    checkOutput("t4_stock1", int'(dut.u_stock.stock), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    pushExp(1'b1, 1'b0, 4'd0, 1'b0, 4'd5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    idle();
    idle();
    checkOutput("t4_sold_out1", int'(vif.po_sold_out), 1);
    pushExp(1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    checkOutput("t4_credit_locked", int'(vif.po_credit), 0);
    pushExp(1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd3);
    checkOutput("t4_stock3", int'(dut.u_stock.stock), 3);
    idle();
    checkOutput("t4_sold_out0", int'(vif.po_sold_out), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    pushExp(1'b1, 1'b0, 4'd0, 1'b0, 4'd5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    idle();
    checkOutput("t4_stock2", int'(dut.u_stock.stock), 2);

    $display("[TB] reset mid-accumulation");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    checkOutput("t6_credit4", int'(vif.po_credit), 4);
    sys_rst = 1'b1;
    idle();
    checkOutput("t6_credit0", int'(vif.po_credit),     0);
    checkOutput("t6_state",   int'(dut.state),         1);
    checkOutput("t6_stock",   int'(dut.u_stock.stock), 10);
    checkOutput("t6_cola",    int'(vif.po_cola),       0);
    checkOutput("t6_vld",     int'(vif.po_change_vld), 0);
    sys_rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    checkOutput("t6_credit1", int'(vif.po_credit), 1);

    repeat (4) idle();
    checkOutput("queue_drained", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
